// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// The arbiter grants one of several producers access to a single FIFO write port.
package fifo_wr_arbiter_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BURST = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker.
// The search starts at the producer after last_grant and finds the first set request.
module rr_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       found
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of a FIFO write port.
// One producer holds the grant for up to MAX_BURST beats, and it stalls in HOLD while the FIFO is full.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic                          wr_en,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [7:0]                    ovf_cnt,
    output logic [15:0]                   ack_cnt
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [7:0]         ovf_q, ovf_d;
    logic [15:0]        ack_q, ack_d;

    logic [IDX_W-1:0]   pick_id;
    logic               pick_found;
    logic               grant_valid;
    logic               almostfull_unused;

    // almostfull is only a hint for the FIFO's own full check; arbitration ignores it.
    assign almostfull_unused = almostfull;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .found      (pick_found)
    );

    assign grant_valid = req_valid[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        req_ready    = '0;
        wr_en        = 1'b0;
        data_in      = '0;

        unique case (state_q)
            ARB: begin
                if (pick_found && !full) begin
                    grant_d = pick_id;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                req_ready[grant_q] = !full;
                if (grant_valid && !full) begin
                    wr_en   = 1'b1;
                    data_in = req_data[grant_q*FIFO_WIDTH +: FIFO_WIDTH];
                    beat_d  = beat_q + 1'b1;
                end
                // A completed burst or a dropped request wins over a full stall.
                if ((wr_en && beat_q == LAST_BEAT) || !grant_valid) begin
                    state_d      = ARB;
                    last_grant_d = grant_q;
                end else if (full) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!grant_valid) begin
                    state_d      = ARB;
                    last_grant_d = grant_q;
                end else if (!full) begin
                    state_d = BURST;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        ovf_d = (overflow && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
        ack_d = wr_ack ? ack_q + 16'd1 : ack_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            beat_q       <= '0;
            ovf_q        <= '0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            ovf_q        <= ovf_d;
            ack_q        <= ack_d;
        end
    end

    assign grant_id = grant_q;
    assign ovf_cnt  = ovf_q;
    assign ack_cnt  = ack_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected writes, a negedge monitor pops them.
// Producers are modelled as beat counters that present base + step*sent on their data slice.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    import fifo_wr_arbiter_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   data_in;
    logic           wr_en;
    logic           full, almostfull, wr_ack, overflow;
    logic [1:0]     grant_id;
    logic [7:0]     ovf_cnt;
    logic [15:0]    ack_cnt;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .data_in(data_in), .wr_en(wr_en),
        .full(full), .almostfull(almostfull), .wr_ack(wr_ack), .overflow(overflow),
        .grant_id(grant_id), .ovf_cnt(ovf_cnt), .ack_cnt(ack_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          stamp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          remaining[N];
    int          sent[N];
    logic [15:0] base[N];
    logic [15:0] step[N];
    logic [N-1:0] fire;
    exp_t        mon_e;
    logic [3:0]  mon_hot;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [15:0] d);
        sb_q.push_back('{id: id, data: d});
    endtask

    task automatic load(input int i, input int n, input logic [15:0] b, input logic [15:0] s);
        remaining[i] = n;
        sent[i]      = 0;
        base[i]      = b;
        step[i]      = s;
    endtask

    // Producer model: count beats accepted at the negedge, present the next beat after the edge.
    always begin
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i] === 1'b1) begin
                remaining[i]--;
                sent[i]++;
            end
            req_valid[i]       = (remaining[i] > 0);
            req_data[i*W +: W] = base[i] + step[i] * 16'(sent[i]);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            stamp_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("unexpected_write", {16'h0, data_in}, 32'hFFFF_FFFF);
            end else begin
                mon_e   = sb_q.pop_front();
                mon_hot = 4'b0001 << mon_e.id;
                check("wr_grant", grant_id, mon_e.id);
                check("wr_data", data_in, mon_e.data);
                check("wr_ready", req_ready, mon_hot);
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || |req_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain"}, sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_sent(input int i, input int target, input string name);
        int n = 0;
        while (sent[i] < target && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(name, sent[i], target);
    endtask

    initial begin
        int t_load;
        rst_n = 1'b1; full = 1'b0; almostfull = 1'b0; wr_ack = 1'b0; overflow = 1'b0;
        for (int i = 0; i < N; i++) load(i, 0, 16'h0, 16'h0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_grant", grant_id, 0);
        check("rst_ready", req_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_data", data_in, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_ack", ack_cnt, 0);
        check("rst_state", dut.state_q, ARB);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // All four producers busy: grants 0,1,2,3 then 0 again, 4 beats each.
        load(0, 8, 16'h1000, 16'h1);
        load(1, 4, 16'h2000, 16'h1);
        load(2, 4, 16'h3000, 16'h1);
        load(3, 4, 16'h4000, 16'h1);
        for (int b = 0; b < 4; b++) push_exp(2'd0, 16'h1000 + 16'(b));
        for (int b = 0; b < 4; b++) push_exp(2'd1, 16'h2000 + 16'(b));
        for (int b = 0; b < 4; b++) push_exp(2'd2, 16'h3000 + 16'(b));
        for (int b = 0; b < 4; b++) push_exp(2'd3, 16'h4000 + 16'(b));
        for (int b = 4; b < 8; b++) push_exp(2'd0, 16'h1000 + 16'(b));
        wait_drain("rr4");
        check("rr4_state", dut.state_q, ARB);

        // Producer 2 alone with 6 beats: 4 writes, one idle ARB cycle, 2 writes.
        stamp_q.delete();
        t_load = cyc;
        load(2, 6, 16'hA5A5, 16'h0);
        for (int b = 0; b < 6; b++) push_exp(2'd2, 16'hA5A5);
        @(posedge clk);
        @(negedge clk);
        check("arb_ready_zero", req_ready, 0);
        check("arb_no_wr", wr_en, 0);
        wait_drain("solo");
        check("solo_count", stamp_q.size(), 6);
        if (stamp_q.size() == 6) begin
            check("solo_first", stamp_q[0] - t_load, 2);
            check("solo_gap1", stamp_q[1] - stamp_q[0], 1);
            check("solo_gap2", stamp_q[2] - stamp_q[1], 1);
            check("solo_gap3", stamp_q[3] - stamp_q[2], 1);
            check("solo_gap4", stamp_q[4] - stamp_q[3], 2);
            check("solo_gap5", stamp_q[5] - stamp_q[4], 1);
        end

        // Producer 1 drops after one beat; producer 2 is granted next.
        stamp_q.delete();
        load(1, 1, 16'h2000, 16'h1);
        load(2, 2, 16'h3000, 16'h1);
        push_exp(2'd1, 16'h2000);
        push_exp(2'd2, 16'h3000);
        push_exp(2'd2, 16'h3001);
        wait_drain("drop");
        check("drop_count", stamp_q.size(), 3);
        if (stamp_q.size() == 3) check("drop_gap", stamp_q[1] - stamp_q[0], 3);

        // Full raised after beat 2 of producer 3: HOLD with grant kept, then beats 3 and 4.
        load(3, 4, 16'h4000, 16'h1);
        for (int b = 0; b < 4; b++) push_exp(2'd3, 16'h4000 + 16'(b));
        wait_sent(3, 2, "hold_reach");
        full = 1'b1;
        @(negedge clk);
        check("full_ready", req_ready, 0);
        check("full_wr", wr_en, 0);
        repeat (3) begin
            @(negedge clk);
            check("hold_state", dut.state_q, HOLD);
            check("hold_wr", wr_en, 0);
            check("hold_ready", req_ready, 0);
            check("hold_grant", grant_id, 3);
        end
        @(posedge clk);
        #2;
        full = 1'b0;
        wait_drain("hold");
        check("hold_end_state", dut.state_q, ARB);

        // Counters: 300 overflow pulses saturate, 65537 wr_ack pulses wrap to 1.
        for (int k = 0; k < 65537; k++) begin
            wr_ack   = 1'b1;
            overflow = (k < 300);
            @(posedge clk);
            #2;
            if (k == 253)   check("ovf_254", ovf_cnt, 254);
            if (k == 254)   check("ovf_255", ovf_cnt, 255);
            if (k == 299)   check("ovf_sat", ovf_cnt, 255);
            if (k == 65534) check("ack_max", ack_cnt, 16'hFFFF);
        end
        wr_ack   = 1'b0;
        overflow = 1'b0;
        @(posedge clk);
        #2;
        check("ack_wrap", ack_cnt, 1);
        check("ovf_final", ovf_cnt, 255);

        // Asynchronous reset in the middle of a burst of producer 1.
        load(1, 4, 16'h2000, 16'h1);
        push_exp(2'd1, 16'h2000);
        push_exp(2'd1, 16'h2001);
        wait_sent(1, 2, "mid_reach");
        check("pre_rst_wr", wr_en, 1);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        #1;
        check("mid_rst_wr", wr_en, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_data", data_in, 0);
        check("mid_rst_grant", grant_id, 0);
        check("mid_rst_ovf", ovf_cnt, 0);
        check("mid_rst_ack", ack_cnt, 0);
        check("mid_rst_state", dut.state_q, ARB);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        load(0, 1, 16'h1000, 16'h1);
        load(1, 1, 16'h2000, 16'h1);
        push_exp(2'd0, 16'h1000);
        push_exp(2'd1, 16'h2000);
        wait_drain("post_rst");

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
